// File: rtl/e155_audio_pkg.sv
// Shared types and constants for the E155 audio path.
// Holds the link-state encoding and the power-up effect settings.
package e155_audio_pkg;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    LOCK = 2'd1,
    RUN  = 2'd2
  } link_state_t;

  localparam logic [3:0] DEF_FREQ  = 4'h1;
  localparam logic [3:0] DEF_SCALE = 4'h1;

endpackage

// File: rtl/param_stabilizer.sv
// Synchronizes the effect switch bus and applies each field only after it has
// been identical at consecutive frame starts, and only when the caller allows it.
module param_stabilizer #(
  parameter int FIELD_W       = 4,
  parameter int NUM_FIELDS    = 2,
  parameter int STABLE_FRAMES = 2,
  parameter logic [FIELD_W*NUM_FIELDS-1:0] DEFAULT_VAL = '0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [FIELD_W*NUM_FIELDS-1:0] sw_in,
  input  logic                          frame_tick,
  input  logic                          apply_en,
  output logic [FIELD_W*NUM_FIELDS-1:0] applied,
  output logic                          update
);

  localparam int W     = FIELD_W * NUM_FIELDS;
  localparam int CNT_W = (STABLE_FRAMES > 2) ? $clog2(STABLE_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_FRAMES - 1);

  logic [W-1:0]          sync_a;
  logic [W-1:0]          sync_b;
  logic [NUM_FIELDS-1:0] take;

  // Reset the synchronizer to the defaults so switches left at their default
  // position never look like a change right after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a <= DEFAULT_VAL;
      sync_b <= DEFAULT_VAL;
    end else begin
      sync_a <= sw_in;
      sync_b <= sync_a;
    end
  end

  for (genvar g = 0; g < NUM_FIELDS; g++) begin : g_field
    logic [FIELD_W-1:0] cur;
    logic [FIELD_W-1:0] cand;
    logic [FIELD_W-1:0] applied_f;
    logic [CNT_W-1:0]   stable_cnt;
    logic [CNT_W-1:0]   cnt_inc;
    logic               match;

    assign cur     = sync_b[g*FIELD_W +: FIELD_W];
    assign match   = (cur == cand);
    assign cnt_inc = (stable_cnt == CNT_MAX) ? stable_cnt : stable_cnt + 1'b1;
    // The sample that loads the candidate counts as the first of the run, so
    // the check is made on the post-increment count.
    assign take[g] = frame_tick && apply_en && match &&
                     (cnt_inc == CNT_MAX) && (cand != applied_f);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cand       <= DEFAULT_VAL[g*FIELD_W +: FIELD_W];
        stable_cnt <= '0;
        applied_f  <= DEFAULT_VAL[g*FIELD_W +: FIELD_W];
      end else begin
        if (frame_tick) begin
          if (match) begin
            stable_cnt <= cnt_inc;
          end else begin
            cand       <= cur;
            stable_cnt <= '0;
          end
        end
        if (take[g]) begin
          applied_f <= cand;
        end
      end
    end

    assign applied[g*FIELD_W +: FIELD_W] = applied_f;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      update <= 1'b0;
    end else begin
      update <= |take;
    end
  end

endmodule

// File: rtl/i2s_link_ctrl.sv
// I2S link controller: locks to word-select framing, gates the datapath reset,
// flags framing loss and applies the effect switches at frame boundaries.
module i2s_link_ctrl #(
  parameter int         BITS_PER_CH         = 16,
  parameter int         LOCK_FRAMES         = 4,
  parameter int         PARAM_STABLE_FRAMES = 2,
  parameter logic [3:0] DEF_FREQ            = e155_audio_pkg::DEF_FREQ,
  parameter logic [3:0] DEF_SCALE           = e155_audio_pkg::DEF_SCALE
) (
  input  logic       sclk_i,
  input  logic       rst_n_i,
  input  logic       ws_i,
  input  logic [3:0] freqSetting_i,
  input  logic [3:0] scaleFactor_i,
  output logic       rstI2S_n_o,
  output logic       frameStart_o,
  output logic [3:0] freqSetting_o,
  output logic [3:0] scaleFactor_o,
  output logic       paramUpdate_o,
  output logic       errorLED_o,
  output logic [7:0] errCount_o
);

  import e155_audio_pkg::link_state_t;
  import e155_audio_pkg::HUNT;
  import e155_audio_pkg::LOCK;
  import e155_audio_pkg::RUN;

  localparam int HC_W = (BITS_PER_CH > 1) ? $clog2(BITS_PER_CH) : 1;
  localparam logic [HC_W-1:0] HALF_LAST = HC_W'(BITS_PER_CH - 1);
  localparam int VC_W = $clog2(2 * LOCK_FRAMES);
  localparam logic [VC_W-1:0] VALID_LAST = VC_W'(2 * LOCK_FRAMES - 1);

  link_state_t     state;
  link_state_t     next_state;
  logic            ws_prev;
  logic [HC_W-1:0] half_cnt;
  logic [VC_W-1:0] valid_cnt;
  logic            ws_edge;
  logic            ws_fall;
  logic            at_limit;
  logic            half_valid;
  logic            half_invalid;
  logic            err_evt;
  logic            frame_evt;
  logic            apply_en;
  logic            run_q;
  logic            frame_start_q;
  logic            err_led_q;
  logic [7:0]      err_cnt_q;
  logic [7:0]      applied;
  logic            param_update;

  assign ws_edge      = ws_i ^ ws_prev;
  assign ws_fall      = ws_prev & ~ws_i;
  assign at_limit     = (half_cnt == HALF_LAST);
  assign half_valid   = ws_edge && at_limit;
  // Either an early edge or a missing edge at the last bit breaks framing.
  assign half_invalid = ws_edge ? !at_limit : at_limit;

  always_ff @(posedge sclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state     <= HUNT;
      ws_prev   <= 1'b0;
      half_cnt  <= '0;
      valid_cnt <= '0;
    end else begin
      state    <= next_state;
      ws_prev  <= ws_i;
      half_cnt <= ws_edge ? '0 : half_cnt + 1'b1;
      if (state != LOCK) begin
        valid_cnt <= '0;
      end else if (half_valid) begin
        valid_cnt <= valid_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    next_state = state;
    err_evt    = 1'b0;
    case (state)
      HUNT: begin
        if (ws_fall) next_state = LOCK;
      end
      LOCK: begin
        if (half_invalid) begin
          next_state = HUNT;
        end else if (half_valid && (valid_cnt == VALID_LAST)) begin
          next_state = RUN;
        end
      end
      RUN: begin
        if (half_invalid) begin
          next_state = HUNT;
          err_evt    = 1'b1;
        end
      end
      default: next_state = HUNT;
    endcase
    frame_evt = ws_fall && (next_state == RUN);
    apply_en  = (state == RUN) && !half_invalid;
  end

  always_ff @(posedge sclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      run_q         <= 1'b0;
      frame_start_q <= 1'b0;
      err_led_q     <= 1'b0;
      err_cnt_q     <= 8'd0;
    end else begin
      run_q         <= (next_state == RUN);
      frame_start_q <= frame_evt;
      if (err_evt) begin
        err_led_q <= 1'b1;
        if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
      end
    end
  end

  param_stabilizer #(
    .FIELD_W       (4),
    .NUM_FIELDS    (2),
    .STABLE_FRAMES (PARAM_STABLE_FRAMES),
    .DEFAULT_VAL   ({DEF_SCALE, DEF_FREQ})
  ) u_param_stabilizer (
    .clk        (sclk_i),
    .rst_n      (rst_n_i),
    .sw_in      ({scaleFactor_i, freqSetting_i}),
    .frame_tick (ws_fall),
    .apply_en   (apply_en),
    .applied    (applied),
    .update     (param_update)
  );

  assign rstI2S_n_o    = run_q;
  assign frameStart_o  = frame_start_q;
  assign errorLED_o    = err_led_q;
  assign errCount_o    = err_cnt_q;
  assign freqSetting_o = applied[3:0];
  assign scaleFactor_o = applied[7:4];
  assign paramUpdate_o = param_update;

endmodule

// File: tb/tb_i2s_link_ctrl.sv
// Directed self-checking bench for i2s_link_ctrl: lock/relock, framing faults,
// switch stabilization and asynchronous reset.
module tb_i2s_link_ctrl;

  logic       sclk_i = 1'b0;
  logic       rst_n_i;
  logic       ws_i;
  logic [3:0] freqSetting_i;
  logic [3:0] scaleFactor_i;
  logic       rstI2S_n_o;
  logic       frameStart_o;
  logic [3:0] freqSetting_o;
  logic [3:0] scaleFactor_o;
  logic       paramUpdate_o;
  logic       errorLED_o;
  logic [7:0] errCount_o;

  int test_count = 0;
  int fail_count = 0;

  i2s_link_ctrl #(
    .BITS_PER_CH         (16),
    .LOCK_FRAMES         (4),
    .PARAM_STABLE_FRAMES (2),
    .DEF_FREQ            (4'h1),
    .DEF_SCALE           (4'h1)
  ) dut (
    .sclk_i        (sclk_i),
    .rst_n_i       (rst_n_i),
    .ws_i          (ws_i),
    .freqSetting_i (freqSetting_i),
    .scaleFactor_i (scaleFactor_i),
    .rstI2S_n_o    (rstI2S_n_o),
    .frameStart_o  (frameStart_o),
    .freqSetting_o (freqSetting_o),
    .scaleFactor_o (scaleFactor_o),
    .paramUpdate_o (paramUpdate_o),
    .errorLED_o    (errorLED_o),
    .errCount_o    (errCount_o)
  );

  always #5 sclk_i = ~sclk_i;

  // Each call drives ws for the given number of sclk cycles; outputs are
  // sampled 1 time unit after the rising edge that consumed the last value.
  task automatic apply_stimulus(input logic ws_val, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      ws_i = ws_val;
      @(posedge sclk_i);
      #1;
    end
  endtask

  task automatic check_output(input string tag, input logic [7:0] observed,
                              input logic [7:0] expected);
    test_count++;
    assert (observed === expected) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic check_link(input string tag, input logic rst_exp,
                            input logic led_exp, input logic [7:0] cnt_exp);
    check_output({tag, "_rst"}, 8'(rstI2S_n_o), 8'(rst_exp));
    check_output({tag, "_led"}, 8'(errorLED_o), 8'(led_exp));
    check_output({tag, "_cnt"}, errCount_o, cnt_exp);
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_rst"},   8'(rstI2S_n_o),    8'd0);
    check_output({tag, "_fs"},    8'(frameStart_o),  8'd0);
    check_output({tag, "_pu"},    8'(paramUpdate_o), 8'd0);
    check_output({tag, "_led"},   8'(errorLED_o),    8'd0);
    check_output({tag, "_cnt"},   errCount_o,        8'd0);
    check_output({tag, "_freq"},  8'(freqSetting_o), 8'd1);
    check_output({tag, "_scale"}, 8'(scaleFactor_o), 8'd1);
  endtask

  // Starts with ws high in HUNT: falling edge enters LOCK, seven valid halves
  // follow, and the eighth valid edge (falling) must enter RUN.
  task automatic lock_sequence(input string tag);
    apply_stimulus(1'b0, 16);
    for (int h = 0; h < 7; h++) apply_stimulus((h % 2 == 0) ? 1'b1 : 1'b0, 16);
    check_output({tag, "_prelock_rst"}, 8'(rstI2S_n_o), 8'd0);
    apply_stimulus(1'b0, 1);
    check_output({tag, "_lock_rst"}, 8'(rstI2S_n_o), 8'd1);
    check_output({tag, "_lock_fs"}, 8'(frameStart_o), 8'd1);
    apply_stimulus(1'b0, 1);
    check_output({tag, "_fs_low"}, 8'(frameStart_o), 8'd0);
    apply_stimulus(1'b0, 14);
  endtask

  // One clean frame starting with the high half; checks at the frame start.
  task automatic frame_check(input string tag, input logic pu_exp,
                             input logic [3:0] freq_exp, input logic [3:0] scale_exp);
    apply_stimulus(1'b1, 16);
    apply_stimulus(1'b0, 1);
    check_output({tag, "_fs"},    8'(frameStart_o),  8'd1);
    check_output({tag, "_pu"},    8'(paramUpdate_o), 8'(pu_exp));
    check_output({tag, "_freq"},  8'(freqSetting_o), 8'(freq_exp));
    check_output({tag, "_scale"}, 8'(scaleFactor_o), 8'(scale_exp));
    apply_stimulus(1'b0, 1);
    check_output({tag, "_pu_next"}, 8'(paramUpdate_o), 8'd0);
    apply_stimulus(1'b0, 14);
  endtask

  initial begin
    rst_n_i       = 1'b0;
    ws_i          = 1'b0;
    freqSetting_i = 4'h1;
    scaleFactor_i = 4'h1;
    repeat (3) @(posedge sclk_i);
    #1;
    check_reset_values("reset");
    rst_n_i = 1'b1;

    // Timeout while in LOCK: back to HUNT with no error recorded.
    apply_stimulus(1'b0, 16);
    apply_stimulus(1'b1, 16);
    apply_stimulus(1'b0, 16);
    apply_stimulus(1'b0, 1);
    check_link("lock_timeout", 1'b0, 1'b0, 8'd0);
    apply_stimulus(1'b0, 4);
    apply_stimulus(1'b1, 16);

    lock_sequence("lock1");
    check_link("lock1_state", 1'b1, 1'b0, 8'd0);

    // Frame pulse one cycle after each falling edge, 32 cycles apart.
    apply_stimulus(1'b1, 16);
    check_output("fs_mid_high", 8'(frameStart_o), 8'd0);
    apply_stimulus(1'b0, 1);
    check_output("fs_period", 8'(frameStart_o), 8'd1);
    apply_stimulus(1'b0, 15);

    // Low half shortened to 15 cycles: early rising edge in RUN.
    apply_stimulus(1'b1, 16);
    apply_stimulus(1'b0, 15);
    apply_stimulus(1'b1, 1);
    check_link("short_half", 1'b0, 1'b1, 8'd1);
    apply_stimulus(1'b1, 15);
    check_link("short_hunt", 1'b0, 1'b1, 8'd1);
    lock_sequence("relock1");
    check_link("relock1_state", 1'b1, 1'b1, 8'd1);

    // ws stuck high in RUN: timeout at the last bit of the half.
    apply_stimulus(1'b1, 16);
    check_output("stuck_before", 8'(rstI2S_n_o), 8'd1);
    apply_stimulus(1'b1, 1);
    check_link("stuck_high", 1'b0, 1'b1, 8'd2);
    apply_stimulus(1'b1, 3);
    lock_sequence("relock2");

    // Frequency 1 -> 5 applied at the second frame start, single pulse.
    freqSetting_i = 4'h5;
    frame_check("freq_f1", 1'b0, 4'h1, 4'h1);
    frame_check("freq_f2", 1'b1, 4'h5, 4'h1);
    frame_check("freq_f3", 1'b0, 4'h5, 4'h1);

    // Scale glitch to 7 seen at exactly one frame start is never applied.
    scaleFactor_i = 4'h7;
    apply_stimulus(1'b1, 16);
    apply_stimulus(1'b0, 1);
    check_output("scale_f1_pu", 8'(paramUpdate_o), 8'd0);
    check_output("scale_f1_scale", 8'(scaleFactor_o), 8'd1);
    scaleFactor_i = 4'h1;
    apply_stimulus(1'b0, 15);
    frame_check("scale_f2", 1'b0, 4'h5, 4'h1);
    frame_check("scale_f3", 1'b0, 4'h5, 4'h1);
    check_link("pre_async", 1'b1, 1'b1, 8'd2);

    // Asynchronous reset between clock edges.
    #2;
    rst_n_i = 1'b0;
    #1;
    check_reset_values("async_reset");

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule

// File: doc/i2s_link_ctrl.md
# i2s_link_ctrl

Link controller for the I2S audio passthrough/effect path. It watches the incoming word-select stream on the bit clock, hunts for and locks to valid frame alignment, and holds the I2S datapath in reset until lock. It raises a sticky error on loss of framing and re-hunts automatically. It also samples the user effect switches and applies them glitch-free at frame boundaries once they are stable.

## Interface
Parameters:
- BITS_PER_CH, 16: sclk cycles per half-frame (one channel).
- LOCK_FRAMES, 4: consecutive valid frames required to declare lock.
- PARAM_STABLE_FRAMES, 2: consecutive identical frame-start samples required before a setting is applied.
- DEF_FREQ, 4'h1 / DEF_SCALE, 4'h1: applied settings after reset.

Ports:
- sclk_i  in  1  bit clock; all logic on rising edge.
- rst_n_i  in  1  reset, asynchronous, active-low.
- ws_i  in  1  word select, synchronous to sclk_i; low = left.
- freqSetting_i  in  4  asynchronous switch input.
- scaleFactor_i  in  4  asynchronous switch input.
- rstI2S_n_o  out  1  datapath reset, active-low.
- frameStart_o  out  1  one-cycle pulse per frame while locked.
- freqSetting_o  out  4  applied frequency setting.
- scaleFactor_o  out  4  applied scale factor.
- paramUpdate_o  out  1  one-cycle pulse when an applied setting changes.
- errorLED_o  out  1  sticky framing-error flag.
- errCount_o  out  8  saturating count of lock losses.

## Operation
- Edge detect: wsPrev registers ws_i. An edge cycle is any cycle where ws_i != wsPrev. A falling edge marks the frame start.
- halfCnt: 0 on the cycle after an edge, then +1 per cycle. A half is valid if an edge occurs while halfCnt == BITS_PER_CH-1.
- A half is invalid if an edge arrives earlier. A half is also invalid on timeout: halfCnt == BITS_PER_CH-1 with no edge.
- States (enum):
  - HUNT: wait for a ws falling edge, then go to LOCK with validCnt = 0.
  - LOCK: each valid edge increments validCnt. When validCnt reaches 2*LOCK_FRAMES, go to RUN. An invalid half sends the block back to HUNT; this does not count as an error.
  - RUN: an invalid half sets errorLED, increments errCount (saturates at 255), and goes to HUNT.
- rstI2S_n_o is high only in RUN.
- errorLED clears only on rst_n_i.
- Parameter path:
  - 2-flop synchronizer per switch bus.
  - At every frame start in any state: if the synced value equals the candidate, increment stableCnt (saturating); otherwise load the candidate from the synced value and clear stableCnt.
  - Switches are not sampled between frame starts.
  - In RUN, at a frame start where synced == candidate, stableCnt == PARAM_STABLE_FRAMES-1, and candidate differs from the applied value: update the applied value and pulse paramUpdate_o.
  - Freq and scale are handled independently. A single paramUpdate_o pulse is issued if either changes.
- A setting that reaches stability outside RUN is applied at the first qualifying frame start in RUN.

## Timing
- Reset values:
  - rstI2S_n_o = 0, frameStart_o = 0, paramUpdate_o = 0, errorLED_o = 0, errCount_o = 0.
  - freqSetting_o = DEF_FREQ, scaleFactor_o = DEF_SCALE.
  - state = HUNT, all counters 0.
- All outputs are registered. Each output changes one sclk after the edge or timeout cycle that causes it.
- frameStart_o pulses the cycle after every ws falling edge while in RUN.
- The LOCK→RUN edge itself produces a frameStart_o pulse only if it is a falling edge.
- Switch-to-output latency is 2 sync cycles plus up to PARAM_STABLE_FRAMES frames plus 1 cycle.
- Simultaneous events:
  - An invalid half on a frame-start edge leaves parameters unchanged and raises the error.
  - An edge at the timeout cycle is valid.
- rst_n_i asserted mid-operation: all outputs take their reset values immediately (asynchronous).

## Structure
- Shared package e155_audio_pkg holds the link state enum (HUNT, LOCK, RUN) and the DEF_FREQ and DEF_SCALE constants.
- One sub-module, param_stabilizer, contains the synchronizer, candidate/stableCnt logic and apply gating. It is instantiated once with an 8-bit concatenated bus.

## Test plan
Settings for all cases: BITS_PER_CH=16, LOCK_FRAMES=4, PARAM_STABLE_FRAMES=2.
- Reset, then clean ws with a 32-cycle period starting low → rstI2S_n_o rises 1 sclk after the 8th valid edge following the first falling edge; errorLED_o = 0; frameStart_o pulses every 32 cycles.
- In RUN, one half shortened to 15 cycles → next cycle errorLED_o = 1, rstI2S_n_o = 0, errCount_o = 1; relock after 8 more valid halves while errorLED_o stays 1.
- In RUN, ws held high → at halfCnt 15 with no edge, error is raised and the block returns to HUNT; the same fault during LOCK returns to HUNT with errorLED_o = 0.
- In RUN, freqSetting_i 1→5 → freqSetting_o = 5 with a single paramUpdate_o pulse at the 2nd frame start after sync; scaleFactor_o unchanged.
- In RUN, scaleFactor_i 1→7 seen at one frame start, then back to 1 → no paramUpdate_o, scaleFactor_o stays 1.
- rst_n_i low mid-RUN with freqSetting_o = 5 → all outputs return to reset values immediately, including freqSetting_o = 1.
